// File: rtl/inp_spk_scanner_if.sv
// Spike event stream between the input scanner and the first-layer
// synaptic accumulation stage.
//
// Handshake: an event transfers on every rising clk edge where both
// spk_valid and spk_ready are high. Once the producer raises spk_valid it
// keeps spk_valid and spk_idx unchanged until that transfer happens.
// spk_valid never depends on spk_ready, but the consumer may raise
// spk_ready at any time.
interface inp_spk_scanner_if #(
  parameter int IDX_WIDTH = 10
) ();
  logic                 spk_valid;
  logic                 spk_ready;
  logic [IDX_WIDTH-1:0] spk_idx;

  modport master (output spk_valid, output spk_idx, input spk_ready);
  modport slave  (input spk_valid, input spk_idx, output spk_ready);
endinterface

// File: rtl/inp_spk_scanner.sv
// Input-spike scanner. It reads one timestep's block of packed spike words
// from the input BRAM and emits one neuron-index event for every set bit,
// lowest bit first. Empty words cost only the read and capture cycles.
module inp_spk_scanner #(
  parameter int RAM_DEPTH      = 32,
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int IDX_WIDTH      = $clog2(RAM_DEPTH*RAM_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [RAM_ADDR_WIDTH:0]   num_words,
  output logic                      busy,
  output logic                      done,
  output logic                      ren,
  output logic [RAM_ADDR_WIDTH-1:0] raddr,
  input  logic [RAM_WIDTH-1:0]      rdat,
  inp_spk_scanner_if.master         spk,
  output logic [2:0]                dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_SCAN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int OFF_W = RAM_ADDR_WIDTH + 1;
  localparam int SUM_W = RAM_ADDR_WIDTH + 2;
  localparam int POS_W = (RAM_WIDTH > 1) ? $clog2(RAM_WIDTH) : 1;

  logic [2:0]                state_q, state_n;
  logic [RAM_ADDR_WIDTH-1:0] base_q, base_n;
  logic [OFF_W-1:0]          nw_q, nw_n;
  logic [OFF_W-1:0]          off_q, off_n;
  logic [RAM_WIDTH-1:0]      w_q, w_n;
  logic [RAM_ADDR_WIDTH-1:0] raddr_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_n;
  logic [SUM_W-1:0]          addr_sum;
  logic [OFF_W-1:0]          nw_sat;
  logic [RAM_WIDTH-1:0]      w_clr;
  logic [POS_W-1:0]          lsb_pos;
  logic                      last_word;
  logic                      last_bit;

  // Word bookkeeping: clamp the requested length, detect the final word,
  // and strip the lowest set bit of the word register.
  always_comb begin
    nw_sat    = (num_words > OFF_W'(RAM_DEPTH)) ? OFF_W'(RAM_DEPTH) : num_words;
    last_word = ((off_q + OFF_W'(1)) == nw_q);
    w_clr     = w_q & (w_q - RAM_WIDTH'(1));
    last_bit  = (w_clr == '0);
  end

  // Priority encoder: position of the lowest set bit of the word register.
  always_comb begin
    lsb_pos = '0;
    for (int i = RAM_WIDTH - 1; i >= 0; i--) begin
      if (w_q[i]) lsb_pos = POS_W'(i);
    end
  end

  // Next-state and datapath update for the scan FSM.
  always_comb begin
    state_n = state_q;
    base_n  = base_q;
    nw_n    = nw_q;
    off_n   = off_q;
    w_n     = w_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            base_n  = base_addr;
            nw_n    = nw_sat;
            off_n   = '0;
            state_n = S_READ;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_READ: state_n = S_CAPT;
      S_CAPT: begin
        w_n = rdat;
        if (rdat == '0) begin
          if (last_word) begin
            state_n = S_DONE;
          end else begin
            off_n   = off_q + OFF_W'(1);
            state_n = S_READ;
          end
        end else begin
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (spk.spk_ready) begin
          w_n = w_clr;
          if (last_bit) begin
            if (last_word) begin
              state_n = S_DONE;
            end else begin
              off_n   = off_q + OFF_W'(1);
              state_n = S_READ;
            end
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Read address for the word about to be fetched, wrapping past the end of
  // the BRAM back to address 0.
  always_comb begin
    addr_sum = SUM_W'(base_n) + SUM_W'(off_n);
    if (addr_sum >= SUM_W'(RAM_DEPTH)) begin
      addr_n = RAM_ADDR_WIDTH'(addr_sum - SUM_W'(RAM_DEPTH));
    end else begin
      addr_n = RAM_ADDR_WIDTH'(addr_sum);
    end
  end

  // State registers; raddr only moves when a read is about to be issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      nw_q    <= '0;
      off_q   <= '0;
      w_q     <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_n;
      base_q  <= base_n;
      nw_q    <= nw_n;
      off_q   <= off_n;
      w_q     <= w_n;
      if (state_n == S_READ) raddr_q <= addr_n;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign ren           = (state_q == S_READ);
  assign raddr         = raddr_q;
  assign dbg_state     = state_q;
  assign spk.spk_valid = (state_q == S_SCAN);
  // Index is relative to the scan base: word offset times word width plus bit.
  assign spk.spk_idx   = IDX_WIDTH'(off_q) * IDX_WIDTH'(RAM_WIDTH) + IDX_WIDTH'(lsb_pos);

endmodule
